// File: rtl/gam_training_sequencer.sv
// Training sequencer: streams store[class][node] patterns to a memory layer, one per WAIT->READY edge.
// ready_wait: 1=READY, 0=WAIT; learning_recall: 0=LEARNING, 1=RECALL. Optional GAM_SEQ_SKIP_ZERO_EN skips zero patterns.
module gam_training_sequencer #(
  parameter int CLASS_COUNT = 4,
  parameter int NODE_COUNT  = 5,
  parameter int X_W         = 128
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           wr_en,
  input  logic [31:0]    wr_class,
  input  logic [31:0]    wr_node,
  input  logic [X_W-1:0] wr_data,
  input  logic           start,
  input  logic [31:0]    class_max,
  input  logic [31:0]    node_max,
  input  logic           ready_wait,
  output logic [X_W-1:0] x,
  output logic [31:0]    c,
  output logic           learning_done,
  output logic           learning_recall,
  output logic           busy,
  output logic           err
);

  localparam int CIW = (CLASS_COUNT > 1) ? $clog2(CLASS_COUNT) : 1;
  localparam int NIW = (NODE_COUNT > 1) ? $clog2(NODE_COUNT) : 1;

  typedef enum logic [1:0] {IDLE, ISSUE, RECALL} state_t;

  state_t         state, state_n;
  logic [X_W-1:0] store [CLASS_COUNT][NODE_COUNT];
  logic [X_W-1:0] x_n, cur;
  logic [31:0]    c_n, cls_cnt, cls_n, node_cnt, node_n;
  logic [31:0]    cls_max_q, cls_max_n, node_max_q, node_max_n;
  logic           done_n, err_n, ready_q, issue_ev, wr_ok, wr_in_range, lim_ok;
  logic           step, last, cur_zero;
  logic [CIW-1:0] wr_ci, rd_ci;
  logic [NIW-1:0] wr_ni, rd_ni;

  assign wr_ci = CIW'(wr_class - 32'd1);
  assign wr_ni = NIW'(wr_node - 32'd1);
  assign rd_ci = CIW'(cls_cnt - 32'd1);
  assign rd_ni = NIW'(node_cnt - 32'd1);
  assign cur      = store[rd_ci][rd_ni];
  assign cur_zero = (cur == '0);
  assign issue_ev = ready_wait && !ready_q;
  assign last     = (cls_cnt == cls_max_q) && (node_cnt == node_max_q);

  assign wr_in_range = (wr_class >= 32'd1) && (wr_class <= 32'(CLASS_COUNT)) &&
                       (wr_node >= 32'd1) && (wr_node <= 32'(NODE_COUNT));
  assign lim_ok = (class_max >= 32'd1) && (class_max <= 32'(CLASS_COUNT)) &&
                  (node_max >= 32'd1) && (node_max <= 32'(NODE_COUNT));

  assign busy            = (state == ISSUE);
  assign learning_recall = (state == RECALL);

  // Store is deliberately outside reset so a run can be replayed after an abort.
  always_ff @(posedge clk) begin
    if (wr_ok) store[wr_ci][wr_ni] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      x             <= '0;
      c             <= '0;
      learning_done <= 1'b0;
      err           <= 1'b0;
      ready_q       <= 1'b0;
      cls_cnt       <= 32'd1;
      node_cnt      <= 32'd1;
      cls_max_q     <= 32'd1;
      node_max_q    <= 32'd1;
    end else begin
      state         <= state_n;
      x             <= x_n;
      c             <= c_n;
      learning_done <= done_n;
      err           <= err_n;
      ready_q       <= ready_wait;
      cls_cnt       <= cls_n;
      node_cnt      <= node_n;
      cls_max_q     <= cls_max_n;
      node_max_q    <= node_max_n;
    end
  end

  always_comb begin
    state_n    = state;
    x_n        = x;
    c_n        = c;
    done_n     = learning_done;
    err_n      = err;
    cls_n      = cls_cnt;
    node_n     = node_cnt;
    cls_max_n  = cls_max_q;
    node_max_n = node_max_q;
    wr_ok      = 1'b0;
    step       = 1'b0;

    case (state)
      ISSUE: begin
`ifdef GAM_SEQ_SKIP_ZERO_EN
        // A zero pattern is stepped over without waiting for (or using) an issue event.
        if (cur_zero) begin
          step = 1'b1;
        end else if (issue_ev) begin
          x_n  = cur;
          c_n  = cls_cnt;
          step = 1'b1;
        end
`else
        if (issue_ev) begin
          x_n  = cur;
          c_n  = cls_cnt;
          step = 1'b1;
          if (cur_zero) err_n = 1'b1;
        end
`endif
      end
      IDLE, RECALL: begin
        if (wr_en && (state == IDLE)) begin
          if (wr_in_range) wr_ok = 1'b1;
          else             err_n = 1'b1;
        end
        if (start) begin
          if (lim_ok) begin
            cls_max_n  = class_max;
            node_max_n = node_max;
            cls_n      = 32'd1;
            node_n     = 32'd1;
            done_n     = 1'b0;
            state_n    = ISSUE;
          end else begin
            err_n = 1'b1;
          end
        end
      end
      default: state_n = IDLE;
    endcase

    if (step) begin
      if (last) begin
        done_n  = 1'b1;
        state_n = RECALL;
      end else if (node_cnt == node_max_q) begin
        node_n = 32'd1;
        cls_n  = cls_cnt + 32'd1;
      end else begin
        node_n = node_cnt + 32'd1;
      end
    end
  end

endmodule

// File: tb/tb_gam_training_sequencer.sv
// Randomized scoreboard bench for gam_training_sequencer against a queue-based run model.
module tb_gam_training_sequencer;

  localparam int CC = 4;
  localparam int NC = 5;
  localparam int XW = 128;

  logic           clk = 1'b0;
  logic           reset, wr_en, start, ready_wait;
  logic [31:0]    wr_class, wr_node, class_max, node_max;
  logic [XW-1:0]  wr_data, x;
  logic [31:0]    c;
  logic           learning_done, learning_recall, busy, err;

  always #5 clk = ~clk;

  gam_training_sequencer #(.CLASS_COUNT(CC), .NODE_COUNT(NC), .X_W(XW)) dut (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_class(wr_class), .wr_node(wr_node),
    .wr_data(wr_data), .start(start), .class_max(class_max), .node_max(node_max),
    .ready_wait(ready_wait), .x(x), .c(c), .learning_done(learning_done),
    .learning_recall(learning_recall), .busy(busy), .err(err)
  );

  typedef struct packed {
    logic [XW-1:0] x;
    logic [31:0]   c;
    logic          done;
  } out_t;

  typedef enum {M_IDLE, M_RUN, M_RECALL} mst_t;

  out_t          exp_q[$];
  int            total = 0;
  int            bad = 0;
  logic          mon_en = 1'b0;
  out_t          last_seen;

  // Reference model: a run is the list of (class,node) pairs still to be presented.
  logic [XW-1:0] m_store [1:CC][1:NC];
  mst_t          m_st;
  out_t          m_out;
  logic          m_err, m_prev;
  int            m_cls_q[$];
  int            m_node_q[$];

  task automatic check(string name, logic [XW-1:0] got, logic [XW-1:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h t=%0t", name, got, want, $time);
    end
  endtask

  task automatic model_step();
    out_t prev = m_out;
    logic ev;
    int cl, nd;
    if (reset) begin
      m_st = M_IDLE; m_out = '0; m_err = 1'b0; m_prev = 1'b0;
      m_cls_q.delete(); m_node_q.delete();
    end else begin
      ev = ready_wait && !m_prev;
      m_prev = ready_wait;
      if (m_st == M_RUN) begin
        cl = m_cls_q[0]; nd = m_node_q[0];
`ifdef GAM_SEQ_SKIP_ZERO_EN
        if (m_store[cl][nd] == '0) begin
          void'(m_cls_q.pop_front()); void'(m_node_q.pop_front());
        end else if (ev) begin
          void'(m_cls_q.pop_front()); void'(m_node_q.pop_front());
          m_out.x = m_store[cl][nd]; m_out.c = cl;
        end
`else
        if (ev) begin
          void'(m_cls_q.pop_front()); void'(m_node_q.pop_front());
          m_out.x = m_store[cl][nd]; m_out.c = cl;
          if (m_store[cl][nd] == '0) m_err = 1'b1;
        end
`endif
        if (m_cls_q.size() == 0) begin
          m_out.done = 1'b1; m_st = M_RECALL;
        end
      end else begin
        if (wr_en && m_st == M_IDLE) begin
          if (wr_class >= 1 && wr_class <= CC && wr_node >= 1 && wr_node <= NC)
            m_store[int'(wr_class)][int'(wr_node)] = wr_data;
          else
            m_err = 1'b1;
        end
        if (start) begin
          if (class_max >= 1 && class_max <= CC && node_max >= 1 && node_max <= NC) begin
            for (int i = 1; i <= int'(class_max); i++)
              for (int j = 1; j <= int'(node_max); j++) begin
                m_cls_q.push_back(i); m_node_q.push_back(j);
              end
            m_out.done = 1'b0; m_st = M_RUN;
          end else begin
            m_err = 1'b1;
          end
        end
      end
    end
    if (m_out !== prev) exp_q.push_back(m_out);
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    check("busy", XW'(busy), XW'(m_st == M_RUN));
    check("err", XW'(err), XW'(m_err));
    check("learning_recall", XW'(learning_recall), XW'(m_st == M_RECALL));
    wr_en = 1'b0;
    start = 1'b0;
  endtask

  task automatic do_write(int cl, int nd, logic [XW-1:0] d);
    wr_en = 1'b1; wr_class = cl; wr_node = nd; wr_data = d;
    tick();
  endtask

  task automatic do_start(int cm, int nm);
    start = 1'b1; class_max = cm; node_max = nm;
    tick();
  endtask

  task automatic pulse_ready(int hi, int lo);
    ready_wait = 1'b1;
    repeat (hi) tick();
    ready_wait = 1'b0;
    repeat (lo) tick();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  function automatic logic [XW-1:0] rand_pat();
    return {$urandom, $urandom, $urandom, $urandom | 32'h1};
  endfunction

  always @(negedge clk) begin
    out_t cur, e;
    if (mon_en) begin
      cur = '{x: x, c: c, done: learning_done};
      if (cur !== last_seen) begin
        if (exp_q.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_update got x=%0h c=%0d done=%0b want no change", x, c, learning_done);
        end else begin
          e = exp_q.pop_front();
          check("x", cur.x, e.x);
          check("c", XW'(cur.c), XW'(e.c));
          check("learning_done", XW'(cur.done), XW'(e.done));
        end
        last_seen = cur;
      end
    end
  end

  initial begin
    reset = 1'b1; wr_en = 1'b0; start = 1'b0; ready_wait = 1'b0;
    wr_class = '0; wr_node = '0; wr_data = '0; class_max = '0; node_max = '0;
    m_out = '0; m_st = M_IDLE; m_err = 1'b0; m_prev = 1'b0;
    tick(); tick();
    reset = 1'b0;
    check("reset_x", x, '0);
    check("reset_c", XW'(c), '0);
    check("reset_done", XW'(learning_done), '0);
    last_seen = '0;
    mon_en = 1'b1;

    // Five-pattern class 1 run; first READY held for 10 cycles must issue once.
    for (int cl = 1; cl <= CC; cl++)
      for (int nd = 1; nd <= NC; nd++) do_write(cl, nd, rand_pat());
    do_write(1, 1, 128'd1234);
    do_write(1, 2, 128'd22313);
    do_write(1, 3, 128'd324234);
    do_write(1, 4, 128'd123000000000000);
    do_write(1, 5, 128'h5a5a);
    do_start(1, 5);
    pulse_ready(10, 2);
    repeat (4) pulse_ready(1, 2);
    pulse_ready(1, 2);

    // Illegal limits and out-of-range writes.
    do_reset();
    do_start(0, 3);
    do_reset();
    do_start(1, 6);
    do_reset();
    do_write(CC + 1, 1, rand_pat());
    do_reset();
    do_write(1, 0, rand_pat());
    do_reset();

    // 2x2 ordering.
    for (int cl = 1; cl <= CC; cl++)
      for (int nd = 1; nd <= NC; nd++) do_write(cl, nd, rand_pat());
    do_start(2, 2);
    repeat (4) pulse_ready(1, 1);

    // Abort after two issues, then replay with READY held through reset.
    do_start(2, 3);
    repeat (2) pulse_ready(1, 1);
    ready_wait = 1'b1;
    do_reset();
    ready_wait = 1'b0;
    tick();
    do_start(2, 3);
    repeat (6) pulse_ready(1, 2);

    // Zero pattern in the middle of a run.
    do_reset();
    do_write(1, 3, '0);
    do_start(1, 5);
    repeat (6) pulse_ready(1, 3);

    // Write and start in the same cycle.
    do_reset();
    wr_en = 1'b1; wr_class = 1; wr_node = 1; wr_data = rand_pat();
    start = 1'b1; class_max = 1; node_max = 2;
    tick();
    repeat (2) pulse_ready(1, 1);

    // Random traffic.
    repeat (30) begin
      if ($urandom_range(0, 3) == 0) do_reset();
      repeat ($urandom_range(0, 3))
        do_write($urandom_range(0, CC + 1), $urandom_range(0, NC + 1),
                 ($urandom_range(0, 7) == 0) ? '0 : rand_pat());
      do_start($urandom_range(0, CC + 1), $urandom_range(0, NC + 1));
      repeat (40) begin
        ready_wait = ($urandom_range(0, 2) == 0);
        wr_en      = ($urandom_range(0, 5) == 0);
        wr_class   = $urandom_range(0, CC + 1);
        wr_node    = $urandom_range(0, NC + 1);
        wr_data    = rand_pat();
        start      = ($urandom_range(0, 15) == 0);
        class_max  = $urandom_range(1, CC);
        node_max   = $urandom_range(1, NC);
        reset      = ($urandom_range(0, 63) == 0);
        tick();
        reset = 1'b0;
      end
    end

    ready_wait = 1'b0;
    repeat (3) tick();
    check("queue_drain", XW'(exp_q.size()), '0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
